// File: rtl/baw_round_sequencer.sv
// Round sequencer for one Black-and-White game: turn order, card masks,
// play legality, round resolution and win counting for two players.
module baw_round_sequencer #(
  parameter int NCARDS     = 9,
  parameter int WIN_TARGET = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              play_valid,
  input  logic [NCARDS-1:0] play_card,
  output logic [2:0]        state,
  output logic              cur_player,
  output logic              leader,
  output logic [3:0]        round,
  output logic [NCARDS-1:0] p1_avail,
  output logic [NCARDS-1:0] p2_avail,
  output logic [3:0]        p1_val,
  output logic [3:0]        p2_val,
  output logic              lead_is_black,
  output logic [1:0]        match_result,
  output logic [3:0]        p1_wins,
  output logic [3:0]        p2_wins,
  output logic              game_over,
  output logic [1:0]        game_result,
  output logic              play_ack,
  output logic              play_err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'b000,
    S_LEAD    = 3'b001,
    S_FOLLOW  = 3'b010,
    S_RESOLVE = 3'b011,
    S_DONE    = 3'b100
  } state_t;

  localparam logic [3:0] WIN_T      = 4'(WIN_TARGET);
  localparam logic [3:0] LAST_ROUND = 4'(NCARDS);
  localparam logic [NCARDS-1:0] ALL_CARDS = {NCARDS{1'b1}};

  state_t            r_state;
  logic              r_cur;
  logic              r_leader;
  logic [3:0]        r_round;
  logic [NCARDS-1:0] r_p1Avail;
  logic [NCARDS-1:0] r_p2Avail;
  logic [3:0]        r_p1Val;
  logic [3:0]        r_p2Val;
  logic              r_leadIsBlack;
  logic [1:0]        r_match;
  logic [3:0]        r_p1Wins;
  logic [3:0]        r_p2Wins;
  logic              r_gameOver;
  logic [1:0]        r_gameResult;
  logic              r_ack;
  logic              r_err;

  logic [3:0]        w_cardIdx;
  logic              w_oneHot;
  logic [NCARDS-1:0] w_curAvail;
  logic              w_legal;
  logic              w_p1RoundWin;
  logic              w_p2RoundWin;
  logic              w_draw;
  logic [3:0]        w_p1WinsNext;
  logic [3:0]        w_p2WinsNext;
  logic              w_nextLeader;
  logic              w_gameEnds;
  logic [1:0]        w_finalResult;

  // A play is legal only as a single card still held by the player to move
  always_comb begin
    w_cardIdx = 4'd0;
    for (int k = 0; k < NCARDS; k++) begin
      if (play_card[k]) w_cardIdx = 4'(k);
    end
    w_oneHot   = (play_card != '0) && ((play_card & (play_card - 1'b1)) == '0);
    w_curAvail = r_cur ? r_p2Avail : r_p1Avail;
    w_legal    = w_oneHot && ((play_card & w_curAvail) != '0);
  end

  always_comb begin
    w_p1RoundWin  = r_p1Val > r_p2Val;
    w_p2RoundWin  = r_p1Val < r_p2Val;
    w_draw        = r_p1Val == r_p2Val;
    w_p1WinsNext  = r_p1Wins + {3'b000, w_p1RoundWin};
    w_p2WinsNext  = r_p2Wins + {3'b000, w_p2RoundWin};
    w_nextLeader  = w_p1RoundWin ? 1'b0 : (w_p2RoundWin ? 1'b1 : r_leader);
    w_gameEnds    = (w_p1WinsNext == WIN_T) || (w_p2WinsNext == WIN_T) ||
                    (r_round == LAST_ROUND);
    if (w_p1WinsNext > w_p2WinsNext)      w_finalResult = 2'b01;
    else if (w_p1WinsNext < w_p2WinsNext) w_finalResult = 2'b10;
    else                                  w_finalResult = 2'b11;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cur         <= 1'b0;
      r_leader      <= 1'b0;
      r_round       <= 4'd0;
      r_p1Avail     <= ALL_CARDS;
      r_p2Avail     <= ALL_CARDS;
      r_p1Val       <= 4'd0;
      r_p2Val       <= 4'd0;
      r_leadIsBlack <= 1'b0;
      r_match       <= 2'b00;
      r_p1Wins      <= 4'd0;
      r_p2Wins      <= 4'd0;
      r_gameOver    <= 1'b0;
      r_gameResult  <= 2'b00;
      r_ack         <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state       <= S_LEAD;
            r_cur         <= 1'b0;
            r_leader      <= 1'b0;
            r_round       <= 4'd1;
            r_p1Avail     <= ALL_CARDS;
            r_p2Avail     <= ALL_CARDS;
            r_p1Val       <= 4'd0;
            r_p2Val       <= 4'd0;
            r_leadIsBlack <= 1'b0;
            r_match       <= 2'b00;
            r_p1Wins      <= 4'd0;
            r_p2Wins      <= 4'd0;
            r_gameOver    <= 1'b0;
            r_gameResult  <= 2'b00;
          end
        end
        S_LEAD, S_FOLLOW: begin
          if (play_valid && w_legal) begin
            r_ack <= 1'b1;
            if (r_cur) begin
              r_p2Avail <= r_p2Avail & ~play_card;
              r_p2Val   <= w_cardIdx;
            end else begin
              r_p1Avail <= r_p1Avail & ~play_card;
              r_p1Val   <= w_cardIdx;
            end
            if (r_state == S_LEAD) begin
              r_state       <= S_FOLLOW;
              r_cur         <= ~r_cur;
              r_leadIsBlack <= w_cardIdx[0];
            end else begin
              r_state <= S_RESOLVE;
            end
          end else if (play_valid) begin
            r_err <= 1'b1;
          end
        end
        S_RESOLVE: begin
          r_match  <= {w_p2RoundWin | w_draw, w_p1RoundWin | w_draw};
          r_p1Wins <= w_p1WinsNext;
          r_p2Wins <= w_p2WinsNext;
          r_leader <= w_nextLeader;
          r_cur    <= w_nextLeader;
          // Round number freezes on the last played round when the game ends
          if (w_gameEnds) begin
            r_state      <= S_DONE;
            r_gameOver   <= 1'b1;
            r_gameResult <= w_finalResult;
          end else begin
            r_state <= S_LEAD;
            r_round <= r_round + 4'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign state         = r_state;
  assign cur_player    = r_cur;
  assign leader        = r_leader;
  assign round         = r_round;
  assign p1_avail      = r_p1Avail;
  assign p2_avail      = r_p2Avail;
  assign p1_val        = r_p1Val;
  assign p2_val        = r_p2Val;
  assign lead_is_black = r_leadIsBlack;
  assign match_result  = r_match;
  assign p1_wins       = r_p1Wins;
  assign p2_wins       = r_p2Wins;
  assign game_over     = r_gameOver;
  assign game_result   = r_gameResult;
  assign play_ack      = r_ack;
  assign play_err      = r_err;

endmodule

// File: tb/tb_baw_round_sequencer.sv
// Self-checking bench for baw_round_sequencer: a table of single-cycle vectors
// plus scripted full games for early win, restart, mid-game reset and final draw.
module tb_baw_round_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       play_valid = 1'b0;
  logic [8:0] play_card = '0;
  logic [2:0] state;
  logic       cur_player, leader, lead_is_black, game_over, play_ack, play_err;
  logic [3:0] round, p1_val, p2_val, p1_wins, p2_wins;
  logic [8:0] p1_avail, p2_avail;
  logic [1:0] match_result, game_result;

  int passCount = 0;
  int checkCount = 0;

  int expLeader, expRound, expP1Wins, expP2Wins;

  typedef struct packed {
    logic [2:0] st;
    logic       cur;
    logic       ld;
    logic [3:0] rnd;
    logic       ack;
    logic       err;
    logic [8:0] p1a;
    logic [8:0] p2a;
    logic [3:0] p1v;
    logic [3:0] p2v;
    logic       lib;
    logic [1:0] match;
    logic [3:0] w1;
    logic [3:0] w2;
    logic       gover;
    logic [1:0] gres;
  } obs_t;

  typedef struct {
    logic       rst;
    logic       st;
    logic       pv;
    logic [8:0] card;
    obs_t       exp;
  } vec_t;

  vec_t vecs[$];

  baw_round_sequencer #(.NCARDS(9), .WIN_TARGET(5)) dut (
    .clk(clk), .reset(reset), .start(start), .play_valid(play_valid),
    .play_card(play_card), .state(state), .cur_player(cur_player),
    .leader(leader), .round(round), .p1_avail(p1_avail), .p2_avail(p2_avail),
    .p1_val(p1_val), .p2_val(p2_val), .lead_is_black(lead_is_black),
    .match_result(match_result), .p1_wins(p1_wins), .p2_wins(p2_wins),
    .game_over(game_over), .game_result(game_result), .play_ack(play_ack),
    .play_err(play_err)
  );

  always #5 clk = ~clk;

  function automatic obs_t mkObs(int s, int c, int l, int r, int a, int e,
                                 int pa1, int pa2, int v1, int v2, int lb,
                                 int m, int w1, int w2, int go, int gr);
    obs_t o;
    o.st = 3'(s); o.cur = 1'(c); o.ld = 1'(l); o.rnd = 4'(r);
    o.ack = 1'(a); o.err = 1'(e); o.p1a = 9'(pa1); o.p2a = 9'(pa2);
    o.p1v = 4'(v1); o.p2v = 4'(v2); o.lib = 1'(lb); o.match = 2'(m);
    o.w1 = 4'(w1); o.w2 = 4'(w2); o.gover = 1'(go); o.gres = 2'(gr);
    return o;
  endfunction

  function automatic vec_t mkVec(int r, int s, int p, int card, obs_t e);
    vec_t v;
    v.rst = 1'(r); v.st = 1'(s); v.pv = 1'(p); v.card = 9'(card); v.exp = e;
    return v;
  endfunction

  function automatic obs_t sampleObs();
    obs_t o;
    o = {state, cur_player, leader, round, play_ack, play_err, p1_avail,
         p2_avail, p1_val, p2_val, lead_is_black, match_result, p1_wins,
         p2_wins, game_over, game_result};
    return o;
  endfunction

  task automatic applyStimulus(input logic r, input logic s, input logic p,
                               input logic [8:0] card);
    reset = r; start = s; play_valid = p; play_card = card;
    @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0; play_valid = 1'b0; play_card = '0;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Plays one round in leader order, then predicts the resolve outcome
  task automatic playRound(input int c1, input int c2);
    logic [8:0] card;
    int who, m, gr;
    bit done;
    for (int k = 0; k < 2; k++) begin
      who = (k == 0) ? expLeader : 1 - expLeader;
      card = '0;
      card[(who == 0) ? c1 : c2] = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b1, card);
      checkOutput("playAck", {63'd0, play_ack}, 64'd1);
    end
    checkOutput("resolveState", {61'd0, state}, 64'd3);
    applyStimulus(1'b0, 1'b0, 1'b0, 9'h000);
    if (c1 > c2) begin m = 1; expP1Wins++; expLeader = 0; end
    else if (c1 < c2) begin m = 2; expP2Wins++; expLeader = 1; end
    else m = 3;
    done = (expP1Wins == 5) || (expP2Wins == 5) || (expRound == 9);
    gr = (expP1Wins > expP2Wins) ? 1 : ((expP1Wins < expP2Wins) ? 2 : 3);
    if (!done) expRound++;
    checkOutput("matchResult", {62'd0, match_result}, 64'(m));
    checkOutput("winCounts", {56'd0, p1_wins, p2_wins}, 64'(expP1Wins * 16 + expP2Wins));
    checkOutput("nextState", {61'd0, state}, done ? 64'd4 : 64'd1);
    checkOutput("nextRound", {60'd0, round}, 64'(expRound));
    checkOutput("nextCur", {62'd0, leader, cur_player}, 64'(expLeader * 3));
    checkOutput("gameResult", {61'd0, game_over, game_result}, done ? 64'(4 + gr) : 64'd0);
  endtask

  task automatic newGame();
    applyStimulus(1'b0, 1'b1, 1'b0, 9'h000);
    expLeader = 0; expRound = 1; expP1Wins = 0; expP2Wins = 0;
    checkOutput("startState", {60'd0, state, cur_player}, 64'd2);
  endtask

  initial begin
    obs_t rstObs;
    rstObs = mkObs(0,0,0,0, 0,0, 'h1FF,'h1FF, 0,0,0, 0,0,0, 0,0);

    vecs.push_back(mkVec(1,0,0,'h000, rstObs));
    vecs.push_back(mkVec(0,0,1,'h010, rstObs));
    vecs.push_back(mkVec(0,1,0,'h000, mkObs(1,0,0,1, 0,0, 'h1FF,'h1FF, 0,0,0, 0,0,0, 0,0)));
    vecs.push_back(mkVec(0,0,1,'h010, mkObs(2,1,0,1, 1,0, 'h1EF,'h1FF, 4,0,0, 0,0,0, 0,0)));
    vecs.push_back(mkVec(0,0,1,'h080, mkObs(3,1,0,1, 1,0, 'h1EF,'h17F, 4,7,0, 0,0,0, 0,0)));
    vecs.push_back(mkVec(0,0,1,'h001, mkObs(1,1,1,2, 0,0, 'h1EF,'h17F, 4,7,0, 2,0,1, 0,0)));
    vecs.push_back(mkVec(0,0,1,'h000, mkObs(1,1,1,2, 0,1, 'h1EF,'h17F, 4,7,0, 2,0,1, 0,0)));
    vecs.push_back(mkVec(0,0,1,'h030, mkObs(1,1,1,2, 0,1, 'h1EF,'h17F, 4,7,0, 2,0,1, 0,0)));
    vecs.push_back(mkVec(0,0,1,'h080, mkObs(1,1,1,2, 0,1, 'h1EF,'h17F, 4,7,0, 2,0,1, 0,0)));
    vecs.push_back(mkVec(0,0,1,'h008, mkObs(2,0,1,2, 1,0, 'h1EF,'h177, 4,3,1, 2,0,1, 0,0)));
    vecs.push_back(mkVec(0,1,1,'h008, mkObs(3,0,1,2, 1,0, 'h1E7,'h177, 3,3,1, 2,0,1, 0,0)));
    vecs.push_back(mkVec(0,0,0,'h000, mkObs(1,1,1,3, 0,0, 'h1E7,'h177, 3,3,1, 3,0,1, 0,0)));
    vecs.push_back(mkVec(0,1,1,'h002, mkObs(2,0,1,3, 1,0, 'h1E7,'h175, 3,1,1, 3,0,1, 0,0)));
    vecs.push_back(mkVec(0,0,1,'h001, mkObs(3,0,1,3, 1,0, 'h1E6,'h175, 0,1,1, 3,0,1, 0,0)));
    vecs.push_back(mkVec(0,0,0,'h000, mkObs(1,1,1,4, 0,0, 'h1E6,'h175, 0,1,1, 2,0,2, 0,0)));
    vecs.push_back(mkVec(0,1,0,'h000, mkObs(1,1,1,4, 0,0, 'h1E6,'h175, 0,1,1, 2,0,2, 0,0)));
    vecs.push_back(mkVec(0,0,1,'h100, mkObs(2,0,1,4, 1,0, 'h1E6,'h075, 0,8,0, 2,0,2, 0,0)));
    vecs.push_back(mkVec(1,0,1,'h001, rstObs));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].st, vecs[i].pv, vecs[i].card);
      checkOutput($sformatf("vec%0d", i), 64'(sampleObs()), 64'(vecs[i].exp));
    end

    // P1 takes five straight rounds and ends the game early
    newGame();
    playRound(8, 7);
    playRound(7, 0);
    playRound(6, 1);
    playRound(5, 2);
    playRound(4, 3);
    checkOutput("earlyWinSummary", {52'd0, p1_wins, round, state, game_over},
                {52'd0, 4'd5, 4'd5, 3'd4, 1'b1});
    applyStimulus(1'b0, 1'b0, 1'b1, 9'h001);
    checkOutput("doneIgnoresPlay", {60'd0, play_ack, play_err, state[2], game_over}, 64'h3);
    applyStimulus(1'b0, 1'b1, 1'b1, 9'h002);
    checkOutput("restartFromDone",
                {30'd0, state, round, p1_avail, p2_avail, play_ack, game_over, p1_wins},
                {30'd0, 3'd1, 4'd1, 9'h1FF, 9'h1FF, 1'b0, 1'b0, 4'd0});

    // Reset while waiting for the follower discards the round
    applyStimulus(1'b0, 1'b0, 1'b1, 9'h004);
    checkOutput("followBeforeReset", {61'd0, state}, 64'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 9'h000);
    checkOutput("midGameReset", {28'd0, state, round, p1_avail, p2_avail, p1_wins, p2_wins},
                {28'd0, 3'd0, 4'd0, 9'h1FF, 9'h1FF, 4'd0, 4'd0});

    // Full nine rounds: four wins each and a final draw
    newGame();
    playRound(2, 1);
    playRound(1, 2);
    playRound(4, 3);
    playRound(3, 4);
    playRound(6, 5);
    playRound(5, 6);
    playRound(8, 7);
    playRound(7, 8);
    playRound(0, 0);
    checkOutput("fullGameSummary", {36'd0, round, p1_avail, p2_avail, game_result},
                {36'd0, 4'd9, 9'h000, 9'h000, 2'b11});

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
